alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Control-side counterpart of the 8-bit ALU: fetches 16-bit instructions, drives ALU operands and opcode,
//  and captures the result and Z/N/C/V flags into architectural registers A, B and FLAGS.
//  Executes conditional jumps on the captured flags. Sits between instruction memory and the ALU.
// PARAMETERS
//  RESET_PC   8'h00   PC value loaded on reset
//  IM_WAIT_OK 1       1: FETCH waits indefinitely for im_valid (no timeout)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous, active-low reset
//  im_req     out  1   instruction fetch request
//  im_addr    out  8   fetch address (= PC)
//  im_valid   in   1   im_data valid; sampled only while im_req=1
//  im_data    in   16  instruction word
//  alu_a      out  8   ALU operand a (= reg A)
//  alu_b      out  8   ALU operand b (= reg B)
//  alu_s      out  4   ALU opcode (0..8)
//  alu_out    in   8   ALU result
//  alu_z/n/c/v in  1   ALU flags, combinational from alu_out
//  reg_a      out  8   architectural A
//  reg_b      out  8   architectural B
//  flags      out  4   {Z,N,C,V} registered
//  halted     out  1   1 once HALT executes
// BEHAVIOUR
//  Reset: pc=RESET_PC, A=B=0, flags=0, ir=0, state=FETCH, halted=0, im_req=0 on the first post-reset cycle.
//  Encoding: ir[15:12]=op; ir[11]=dst (0=A, 1=B); ir[7:0]=imm/target.
//   op 0..8 = ALU op (add, sub, and, or, xor, not a, not b, shl, shr), result -> dst.
//   9 = LDA imm; A=ir[7:0]. A = LDB imm; B=ir[7:0]. B = JMP.
//   C = JZ (Z=1). D = JNZ (Z=0). E = JC (C=1). F = HALT.
//  FSM: FETCH -> EXEC -> FETCH; HALT -> HALTED (absorbing until rst_n=0).
//   FETCH: im_req=1, im_addr=pc; hold until im_valid=1; then ir<=im_data, pc<=pc+1 (8-bit wrap FF->00) -> EXEC.
//   EXEC: one cycle. alu_s=ir[15:12] for ALU ops, else 0. alu_a=A and alu_b=B always.
//    ALU op: dst<=alu_out; flags<={alu_z,alu_n,alu_c,alu_v}, same edge.
//    LDA/LDB: load imm; flags unchanged.
//    Jumps: if taken, pc<=ir[7:0], overriding the increment; flags unchanged.
//    HALT: halted<=1 -> HALTED (im_req=0, no register change).
//  Latency: instruction = fetch wait cycles + 2; with im_valid already high in FETCH, 2 cycles per instruction.
//  Flags tested by a jump are those registered by the most recent ALU op; no forwarding needed (strict sequencing).
//  im_valid outside FETCH is ignored; im_req deasserts in the cycle after acceptance.
//  Reset asserted mid-FETCH or mid-EXEC: the pending instruction is dropped with no write; all state returns to reset values.
//  Flags are never written by non-ALU ops. V/C semantics are taken verbatim from the ALU (sub C = borrow).
// STRUCTURE
//  Shared package: opcode localparams (OP_ADD..OP_SHR, OP_LDA, OP_LDB, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_HALT);
//   FSM state encoding (ST_FETCH, ST_EXEC, ST_HALTED); flag bit indices (FZ=3, FN=2, FC=1, FV=0).
//  No sub-modules inside; the ALU is instantiated beside this block at the top level, not inside it.
//  The bench may instantiate the real ALU together with this block.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clocks -> im_req=0, pc=00, A=B=00, flags=0, halted=0; first FETCH im_addr=00.
//  2 Program LDA 7F; LDB 01; ADD->A; JZ 10 -> A=80, flags Z0 N1 C0 V1; jump not taken; next im_addr=04.
//  3 LDA 05; LDB 05; SUB->B; JZ 20 -> B=00, Z=1, C=0; pc=20 next; A unchanged at 05.
//  4 LDA 81; SHL->A; JC 40 -> A=02, C=1; jump taken to 40. JNZ with Z=0 also taken.
//  5 Fetch stall: delay im_valid 5 cycles -> im_req and im_addr held stable; no register change;
//    then pc=FF executes and wraps pc to 00.
//  6 HALT, then toggle im_valid -> halted=1, im_req=0 forever.
//    Reset mid-EXEC of an ADD -> no write to A/flags.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, flag bit positions.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOTA = 4'h5;
  localparam logic [3:0] OP_NOTB = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDA  = 4'h9;
  localparam logic [3:0] OP_LDB  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // {Z,N,C,V} positions inside the flags register
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  // Stall budget used only when fetch is not allowed to wait forever
  localparam logic [7:0] FETCH_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external 8-bit ALU.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_FETCH  | im_req high, waiting for im_valid; latch ir and bump pc
// ST_EXEC   | one cycle: ALU writeback, immediate load, jump or halt
// ST_HALTED | absorbing; only rst_n leaves it
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter bit         IM_WAIT_OK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [7:0]  im_addr,
  input  logic        im_valid,
  input  logic [15:0] im_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_s,
  input  logic [7:0]  alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_b,
  output logic [3:0]  flags,
  output logic        halted
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pc, w_pc_nxt;
  logic [7:0]  r_a, w_a_nxt;
  logic [7:0]  r_b, w_b_nxt;
  logic [3:0]  r_flags, w_flags_nxt;
  logic [15:0] r_ir, w_ir_nxt;
  logic        r_halted, w_halted_nxt;
  logic        r_live;
  logic [7:0]  r_wait_cnt;

  logic [3:0]  w_op;
  logic        w_dst;
  logic [7:0]  w_imm;
  logic        w_accept;
  logic        w_timeout;
  logic [3:0]  w_alu_s;
  logic        w_unused_ir;

  assign w_op        = r_ir[15:12];
  assign w_dst       = r_ir[11];
  assign w_imm       = r_ir[7:0];
  assign w_unused_ir = ^r_ir[10:8];

  // r_live holds im_req low for the first cycle after reset release
  assign im_req    = r_live && (r_state == ST_FETCH);
  assign w_accept  = im_req && im_valid;
  assign w_timeout = !IM_WAIT_OK && im_req && !im_valid && (r_wait_cnt == '0);

  assign im_addr = r_pc;
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_s   = w_alu_s;
  assign reg_a   = r_a;
  assign reg_b   = r_b;
  assign flags   = r_flags;
  assign halted  = r_halted;

  // Next-state, architectural updates and ALU opcode for the current state
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_flags_nxt  = r_flags;
    w_ir_nxt     = r_ir;
    w_halted_nxt = r_halted;
    w_alu_s      = 4'h0;
    case (r_state)
      ST_FETCH: begin
        if (w_accept) begin
          w_ir_nxt    = im_data;
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = ST_EXEC;
        end else if (w_timeout) begin
          w_halted_nxt = 1'b1;
          w_state_nxt  = ST_HALTED;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        if (is_alu_op(w_op)) begin
          w_alu_s     = w_op;
          w_flags_nxt = {alu_z, alu_n, alu_c, alu_v};
          if (w_dst) w_b_nxt = alu_out;
          else       w_a_nxt = alu_out;
        end else begin
          case (w_op)
            OP_LDA:  w_a_nxt = w_imm;
            OP_LDB:  w_b_nxt = w_imm;
            OP_JMP:  w_pc_nxt = w_imm;
            OP_JZ:   if (r_flags[FZ])  w_pc_nxt = w_imm;
            OP_JNZ:  if (!r_flags[FZ]) w_pc_nxt = w_imm;
            OP_JC:   if (r_flags[FC])  w_pc_nxt = w_imm;
            OP_HALT: begin
              w_halted_nxt = 1'b1;
              w_state_nxt  = ST_HALTED;
            end
            default: ;
          endcase
        end
      end
      ST_HALTED: ;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // State and architectural registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_a      <= '0;
      r_b      <= '0;
      r_flags  <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_flags  <= w_flags_nxt;
      r_ir     <= w_ir_nxt;
      r_halted <= w_halted_nxt;
      r_live   <= 1'b1;
    end
  end

  // Fetch stall down-counter; reloads whenever fetch is not actively stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= FETCH_TIMEOUT;
    end else if (im_req && !im_valid && (r_wait_cnt != '0)) begin
      r_wait_cnt <= r_wait_cnt - 8'd1;
    end else if (!(im_req && !im_valid)) begin
      r_wait_cnt <= FETCH_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural ALU beside the sequencer, ISA-level reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_req;
  logic [7:0]  im_addr;
  logic        im_valid;
  logic [15:0] im_data;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_s;
  logic [7:0]  alu_out;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic [7:0]  reg_a, reg_b;
  logic [3:0]  flags;
  logic        halted;

  int n_vec  = 0;
  int n_fail = 0;

  // architectural reference state
  logic [7:0] m_pc, m_a, m_b;
  logic [3:0] m_fl;
  logic       m_halt;

  alu_sequencer #(.RESET_PC(8'h00), .IM_WAIT_OK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr),
    .im_valid(im_valid), .im_data(im_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .reg_a(reg_a), .reg_b(reg_b), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  // returns {result, Z, N, C, V}
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
    int ai, bi, ri;
    logic [7:0] r;
    logic c, v;
    ai = int'(a); bi = int'(b);
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (s)
      4'd0: begin
        ri = ai + bi; r = ri[7:0]; c = (ri > 255);
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        ri = ai - bi; r = ri[7:0]; c = (ai < bi);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = ~b;
      4'd7: begin ri = ai * 2; r = ri[7:0]; c = a[7]; end
      4'd8: begin ri = ai / 2; r = ri[7:0]; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {r, (r == 8'h00), r[7], c, v};
  endfunction

  // stand-in for the real ALU sitting next to the sequencer
  always_comb {alu_out, alu_z, alu_n, alu_c, alu_v} = alu_ref(alu_a, alu_b, alu_s);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00; m_fl = 4'h0; m_halt = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] ins);
    logic [3:0]  op;
    logic [11:0] res;
    op = ins[15:12];
    m_pc = m_pc + 8'd1;
    if (op <= 4'd8) begin
      res = alu_ref(m_a, m_b, op);
      if (ins[11]) m_b = res[11:4];
      else         m_a = res[11:4];
      m_fl = res[3:0];
    end else if (op == 4'h9) m_a = ins[7:0];
    else if (op == 4'hA) m_b = ins[7:0];
    else if (op == 4'hB) m_pc = ins[7:0];
    else if (op == 4'hC) begin if (m_fl[3])  m_pc = ins[7:0]; end
    else if (op == 4'hD) begin if (!m_fl[3]) m_pc = ins[7:0]; end
    else if (op == 4'hE) begin if (m_fl[1])  m_pc = ins[7:0]; end
    else m_halt = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!im_req && n < 8) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check("req_wait", {15'd0, im_req}, 16'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; im_valid = 1'b0; im_data = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_req",   {15'd0, im_req}, 16'd0);
    check("rst_addr",  {8'd0, im_addr}, 16'h0000);
    check("rst_a",     {8'd0, reg_a},   16'h0000);
    check("rst_b",     {8'd0, reg_b},   16'h0000);
    check("rst_flags", {12'd0, flags},  16'h0000);
    check("rst_halt",  {15'd0, halted}, 16'd0);
    rst_n = 1'b1;
    wait_req();
    check("rst_fetch_addr", {8'd0, im_addr}, 16'h0000);
  endtask

  // one instruction: entered and left at a negedge with the DUT in FETCH
  task automatic run_instr(input logic [15:0] ins, input int stall);
    logic [3:0] exp_s;
    check("fetch_req",  {15'd0, im_req}, 16'd1);
    check("fetch_addr", {8'd0, im_addr}, {8'd0, m_pc});
    for (int i = 0; i < stall; i++) begin
      im_valid = 1'b0; im_data = 16'($urandom);
      @(posedge clk); @(negedge clk);
      check("stall_req",  {15'd0, im_req}, 16'd1);
      check("stall_addr", {8'd0, im_addr}, {8'd0, m_pc});
      check("stall_ab",   {reg_a, reg_b},  {m_a, m_b});
    end
    im_valid = 1'b1; im_data = ins;
    @(posedge clk); @(negedge clk);
    exp_s = (ins[15:12] <= 4'd8) ? ins[15:12] : 4'd0;
    check("exec_req",   {15'd0, im_req}, 16'd0);
    check("exec_alu_s", {12'd0, alu_s},  {12'd0, exp_s});
    check("exec_alu_ab", {alu_a, alu_b}, {m_a, m_b});
    im_valid = 1'($urandom); im_data = 16'($urandom);
    @(posedge clk); @(negedge clk);
    im_valid = 1'b0;
    model_exec(ins);
    check("wb_ab",    {reg_a, reg_b},  {m_a, m_b});
    check("wb_flags", {12'd0, flags},  {12'd0, m_fl});
    check("wb_halt",  {15'd0, halted}, {15'd0, m_halt});
  endtask

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0; im_valid = 1'b0; im_data = 16'h0000;
    @(negedge clk);

    // reset values
    do_reset();

    // positive overflow into A, JZ not taken
    run_instr(16'h907F, 0);
    run_instr(16'hA001, 0);
    run_instr(16'h0000, 0);
    run_instr(16'hC010, 0);
    check("t2_a",     {8'd0, reg_a},   16'h0080);
    check("t2_flags", {12'd0, flags},  16'h0005);
    check("t2_addr",  {8'd0, im_addr}, 16'h0004);

    // SUB to zero into B, JZ taken
    run_instr(16'h9005, 1);
    run_instr(16'hA005, 0);
    run_instr(16'h1800, 2);
    run_instr(16'hC020, 0);
    check("t3_b",     {8'd0, reg_b},   16'h0000);
    check("t3_a",     {8'd0, reg_a},   16'h0005);
    check("t3_flags", {12'd0, flags},  16'h0008);
    check("t3_addr",  {8'd0, im_addr}, 16'h0020);

    // SHL carry out, JC and JNZ taken
    run_instr(16'h9081, 0);
    run_instr(16'h7000, 0);
    check("t4_a",     {8'd0, reg_a},  16'h0002);
    check("t4_flags", {12'd0, flags}, 16'h0002);
    run_instr(16'hE040, 0);
    check("t4_jc",  {8'd0, im_addr}, 16'h0040);
    run_instr(16'hD050, 0);
    check("t4_jnz", {8'd0, im_addr}, 16'h0050);

    // long fetch stall at FF, pc wraps to 00
    run_instr(16'hB0FF, 0);
    check("t5_at_ff", {8'd0, im_addr}, 16'h00FF);
    run_instr(16'h903C, 5);
    check("t5_wrap", {8'd0, im_addr}, 16'h0000);
    check("t5_a",    {8'd0, reg_a},   16'h003C);

    // randomized programs, no HALT
    for (int k = 0; k < 150; k++) begin
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ins, int'($urandom_range(0, 3)));
    end

    // HALT is absorbing
    run_instr(16'hF000, 0);
    for (int k = 0; k < 10; k++) begin
      im_valid = 1'($urandom); im_data = 16'($urandom);
      @(posedge clk); @(negedge clk);
      check("halt_req",  {15'd0, im_req}, 16'd0);
      check("halt_flag", {15'd0, halted}, 16'd1);
      check("halt_ab",   {reg_a, reg_b},  {m_a, m_b});
    end

    // reset lands during EXEC of an ADD: nothing is written
    do_reset();
    run_instr(16'h9040, 0);
    run_instr(16'hA040, 0);
    im_valid = 1'b1; im_data = 16'h0000;
    @(posedge clk); @(negedge clk);
    check("mid_exec_state", {15'd0, im_req}, 16'd0);
    im_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    model_reset();
    check("mid_rst_a",     {8'd0, reg_a},   16'h0000);
    check("mid_rst_flags", {12'd0, flags},  16'h0000);
    check("mid_rst_req",   {15'd0, im_req}, 16'd0);
    rst_n = 1'b1;
    wait_req();
    check("mid_rst_addr", {8'd0, im_addr}, 16'h0000);
    run_instr(16'h9011, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
